// File: rtl/frame_assemble_if.sv
// frame_assemble_if
//   Groups the stream inputs and the frame-level handshakes of frame_assemble.
//   Code-rate encodings CODE_RATE_2 / CODE_RATE_3 are defined here if not
//   already provided by param_def.sv.
//
//   Signals (direction seen from the slave = frame_assemble):
//     en_a               in   global enable
//     i_code_rate        in   CODE_RATE_2 / CODE_RATE_3
//     i_enc_sym[2:0]     in   encoder symbol, bit0 first
//     i_enc_valid        in   encoder symbol valid
//     i_dec_bit          in   decoded bit
//     i_dec_valid        in   decoded bit valid
//     i_enc_frame_ready  in   consumer accepts o_encoder_frame
//     i_dec_frame_ready  in   consumer accepts o_decoder_frame
//     o_encoder_frame    out  CODE_FRAME_W assembled encoded frame
//     o_enc_frame_valid  out  encoded frame available
//     o_decoder_frame    out  DATA_FRAME_W assembled data frame
//     o_dec_frame_valid  out  data frame available
//     o_enc_overflow     out  sticky encoded-frame overwrite flag
//     o_dec_overflow     out  sticky data-frame overwrite flag
//     o_enc_parity       out  even parity of o_encoder_frame
//     o_dec_parity       out  even parity of o_decoder_frame
//
//   Modports: master = cores/host side, slave = frame_assemble.

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

interface frame_assemble_if #(
    parameter int DATA_FRAME_W = 128,
    parameter int CODE_FRAME_W = 3 * DATA_FRAME_W
);
    logic                    en_a;
    logic                    i_code_rate;
    logic [2:0]              i_enc_sym;
    logic                    i_enc_valid;
    logic                    i_dec_bit;
    logic                    i_dec_valid;
    logic                    i_enc_frame_ready;
    logic                    i_dec_frame_ready;
    logic [CODE_FRAME_W-1:0] o_encoder_frame;
    logic                    o_enc_frame_valid;
    logic [DATA_FRAME_W-1:0] o_decoder_frame;
    logic                    o_dec_frame_valid;
    logic                    o_enc_overflow;
    logic                    o_dec_overflow;
    logic                    o_enc_parity;
    logic                    o_dec_parity;

    modport master (
        output en_a, i_code_rate, i_enc_sym, i_enc_valid, i_dec_bit, i_dec_valid,
               i_enc_frame_ready, i_dec_frame_ready,
        input  o_encoder_frame, o_enc_frame_valid, o_decoder_frame, o_dec_frame_valid,
               o_enc_overflow, o_dec_overflow, o_enc_parity, o_dec_parity
    );

    modport slave (
        input  en_a, i_code_rate, i_enc_sym, i_enc_valid, i_dec_bit, i_dec_valid,
               i_enc_frame_ready, i_dec_frame_ready,
        output o_encoder_frame, o_enc_frame_valid, o_decoder_frame, o_dec_frame_valid,
               o_enc_overflow, o_dec_overflow, o_enc_parity, o_dec_parity
    );
endinterface

// File: rtl/frame_assemble.sv
// frame_assemble
//   Packs serial convolutional-encoder symbols (2 or 3 bits each) into a
//   CODE_FRAME_W encoded frame and serial Viterbi output bits into a
//   DATA_FRAME_W data frame. The first bit received lands in the MSB of the
//   frame. Each side has its own valid/ready output handshake and a sticky
//   overflow flag raised when an unaccepted frame is overwritten.
//
//   Ports:
//     clk   system clock
//     rst   synchronous reset, active-low
//     bus   frame_assemble_if.slave (streams, rate, enable, frame handshakes)
//
//   Optional feature: define FRAME_PARITY_EN to build the frame parity
//   registers; otherwise o_enc_parity / o_dec_parity are tied to 0.

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module frame_assemble #(
    parameter int DATA_FRAME_W = 128,
    parameter int CODE_FRAME_W = 3 * DATA_FRAME_W
) (
    input  logic             clk,
    input  logic             rst,
    frame_assemble_if.slave  bus
);
    localparam int ENC_PTR_W = $clog2(CODE_FRAME_W);
    localparam int DEC_PTR_W = $clog2(DATA_FRAME_W);

    localparam logic [ENC_PTR_W-1:0] ENC_TOP_R2  = ENC_PTR_W'(2 * DATA_FRAME_W - 1);
    localparam logic [ENC_PTR_W-1:0] ENC_TOP_R3  = ENC_PTR_W'(CODE_FRAME_W - 1);
    localparam logic [ENC_PTR_W-1:0] ENC_LAST_R2 = ENC_PTR_W'(1);
    localparam logic [ENC_PTR_W-1:0] ENC_LAST_R3 = ENC_PTR_W'(2);
    localparam logic [DEC_PTR_W-1:0] DEC_TOP     = DEC_PTR_W'(DATA_FRAME_W - 1);

    // encoder side state
    logic                    rate_q,       rate_d;
    logic [ENC_PTR_W-1:0]    enc_ptr_q,    enc_ptr_d;
    logic [CODE_FRAME_W-1:0] enc_shadow_q, enc_shadow_d;
    logic [CODE_FRAME_W-1:0] enc_frame_q,  enc_frame_d;
    logic                    enc_valid_q,  enc_valid_d;
    logic                    enc_ovf_q,    enc_ovf_d;

    // decoder side state
    logic [DEC_PTR_W-1:0]    dec_ptr_q,    dec_ptr_d;
    logic [DATA_FRAME_W-1:0] dec_shadow_q, dec_shadow_d;
    logic [DATA_FRAME_W-1:0] dec_frame_q,  dec_frame_d;
    logic                    dec_valid_q,  dec_valid_d;
    logic                    dec_ovf_q,    dec_ovf_d;

    logic                    enc_accept, enc_rate3, enc_last;
    logic                    dec_accept, dec_last;
    logic [CODE_FRAME_W-1:0] enc_merged;
    logic [DATA_FRAME_W-1:0] dec_merged;

    // Encoder: the merged vector is the shadow with the current symbol
    // already written, so the completing edge loads the full frame.
    always_comb begin
        enc_accept = bus.en_a & bus.i_enc_valid;
        enc_rate3  = (rate_q == `CODE_RATE_3);
        enc_last   = enc_accept & (enc_ptr_q == (enc_rate3 ? ENC_LAST_R3 : ENC_LAST_R2));

        enc_merged = enc_shadow_q;
        if (enc_accept) begin
            enc_merged[enc_ptr_q]                  = bus.i_enc_sym[0];
            enc_merged[enc_ptr_q - ENC_PTR_W'(1)]  = bus.i_enc_sym[1];
            if (enc_rate3) begin
                enc_merged[enc_ptr_q - ENC_PTR_W'(2)] = bus.i_enc_sym[2];
            end
        end

        rate_d       = rate_q;
        enc_ptr_d    = enc_ptr_q;
        enc_shadow_d = enc_shadow_q;
        enc_frame_d  = enc_frame_q;
        enc_valid_d  = enc_valid_q;
        enc_ovf_d    = enc_ovf_q;

        if (enc_last) begin
            // a waiting frame that is not taken on this edge gets overwritten
            enc_ovf_d    = enc_ovf_q | (enc_valid_q & ~bus.i_enc_frame_ready);
            enc_frame_d  = enc_merged;
            enc_valid_d  = 1'b1;
            enc_shadow_d = '0;
            rate_d       = bus.i_code_rate;
            enc_ptr_d    = (bus.i_code_rate == `CODE_RATE_3) ? ENC_TOP_R3 : ENC_TOP_R2;
        end else begin
            if (enc_accept) begin
                enc_shadow_d = enc_merged;
                enc_ptr_d    = enc_ptr_q - (enc_rate3 ? ENC_PTR_W'(3) : ENC_PTR_W'(2));
            end
            if (bus.i_enc_frame_ready) begin
                enc_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        dec_accept = bus.en_a & bus.i_dec_valid;
        dec_last   = dec_accept & (dec_ptr_q == '0);

        dec_merged = dec_shadow_q;
        if (dec_accept) begin
            dec_merged[dec_ptr_q] = bus.i_dec_bit;
        end

        dec_ptr_d    = dec_ptr_q;
        dec_shadow_d = dec_shadow_q;
        dec_frame_d  = dec_frame_q;
        dec_valid_d  = dec_valid_q;
        dec_ovf_d    = dec_ovf_q;

        if (dec_last) begin
            dec_ovf_d    = dec_ovf_q | (dec_valid_q & ~bus.i_dec_frame_ready);
            dec_frame_d  = dec_merged;
            dec_valid_d  = 1'b1;
            dec_shadow_d = '0;
            dec_ptr_d    = DEC_TOP;
        end else begin
            if (dec_accept) begin
                dec_shadow_d = dec_merged;
                dec_ptr_d    = dec_ptr_q - DEC_PTR_W'(1);
            end
            if (bus.i_dec_frame_ready) begin
                dec_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // rate is taken from the input while reset is held
            rate_q       <= bus.i_code_rate;
            enc_ptr_q    <= (bus.i_code_rate == `CODE_RATE_3) ? ENC_TOP_R3 : ENC_TOP_R2;
            enc_shadow_q <= '0;
            enc_frame_q  <= '0;
            enc_valid_q  <= 1'b0;
            enc_ovf_q    <= 1'b0;
            dec_ptr_q    <= DEC_TOP;
            dec_shadow_q <= '0;
            dec_frame_q  <= '0;
            dec_valid_q  <= 1'b0;
            dec_ovf_q    <= 1'b0;
        end else begin
            rate_q       <= rate_d;
            enc_ptr_q    <= enc_ptr_d;
            enc_shadow_q <= enc_shadow_d;
            enc_frame_q  <= enc_frame_d;
            enc_valid_q  <= enc_valid_d;
            enc_ovf_q    <= enc_ovf_d;
            dec_ptr_q    <= dec_ptr_d;
            dec_shadow_q <= dec_shadow_d;
            dec_frame_q  <= dec_frame_d;
            dec_valid_q  <= dec_valid_d;
            dec_ovf_q    <= dec_ovf_d;
        end
    end

`ifdef FRAME_PARITY_EN
    logic enc_parity_q, enc_parity_d;
    logic dec_parity_q, dec_parity_d;

    // parity is taken from the frame being loaded, so it tracks the frame register
    always_comb begin
        enc_parity_d = enc_parity_q;
        dec_parity_d = dec_parity_q;
        if (enc_last) begin
            enc_parity_d = ^enc_merged;
        end
        if (dec_last) begin
            dec_parity_d = ^dec_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            enc_parity_q <= 1'b0;
            dec_parity_q <= 1'b0;
        end else begin
            enc_parity_q <= enc_parity_d;
            dec_parity_q <= dec_parity_d;
        end
    end

    assign bus.o_enc_parity = enc_parity_q;
    assign bus.o_dec_parity = dec_parity_q;
`else
    assign bus.o_enc_parity = 1'b0;
    assign bus.o_dec_parity = 1'b0;
`endif

    assign bus.o_encoder_frame   = enc_frame_q;
    assign bus.o_enc_frame_valid = enc_valid_q;
    assign bus.o_enc_overflow    = enc_ovf_q;
    assign bus.o_decoder_frame   = dec_frame_q;
    assign bus.o_dec_frame_valid = dec_valid_q;
    assign bus.o_dec_overflow    = dec_ovf_q;

endmodule

// File: tb/tb_frame_assemble.sv
// tb_frame_assemble
//   Self-checking bench for frame_assemble. A bit-queue reference model
//   predicts every output after each clock edge; table-driven encoder frames
//   and hand-written decoder / gap / reset sequences also check against
//   fixed expected frames; a randomized phase exercises both sides together.

`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_frame_assemble;
    localparam int DW = 128;
    localparam int CW = 384;

    logic clk;
    logic rst;

    frame_assemble_if #(.DATA_FRAME_W(DW), .CODE_FRAME_W(CW)) bus ();

    frame_assemble #(.DATA_FRAME_W(DW), .CODE_FRAME_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic          m_rate;
    bit            enc_bits[$];
    bit            dec_bits[$];
    logic [CW-1:0] m_enc_frame;
    logic          m_enc_valid, m_enc_ovf, m_enc_par;
    logic [DW-1:0] m_dec_frame;
    logic          m_dec_valid, m_dec_ovf, m_dec_par;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Predicts the state after the coming edge from the inputs now applied.
    task automatic model_step();
        logic [CW-1:0] f;
        logic [DW-1:0] g;
        int n;
        if (!rst) begin
            m_rate = bus.i_code_rate;
            enc_bits.delete();
            dec_bits.delete();
            m_enc_frame = '0; m_enc_valid = 1'b0; m_enc_ovf = 1'b0; m_enc_par = 1'b0;
            m_dec_frame = '0; m_dec_valid = 1'b0; m_dec_ovf = 1'b0; m_dec_par = 1'b0;
            return;
        end
        if (bus.en_a && bus.i_enc_valid) begin
            enc_bits.push_back(bus.i_enc_sym[0]);
            enc_bits.push_back(bus.i_enc_sym[1]);
            if (m_rate == `CODE_RATE_3) enc_bits.push_back(bus.i_enc_sym[2]);
        end
        n = (m_rate == `CODE_RATE_3) ? 3 * DW : 2 * DW;
        if (enc_bits.size() == n) begin
            f = '0;
            for (int i = 0; i < n; i++) f[n - 1 - i] = enc_bits[i];
            if (m_enc_valid && !bus.i_enc_frame_ready) m_enc_ovf = 1'b1;
            m_enc_valid = 1'b1;
            m_enc_frame = f;
            m_enc_par   = ^f;
            m_rate      = bus.i_code_rate;
            enc_bits.delete();
        end else if (bus.i_enc_frame_ready) begin
            m_enc_valid = 1'b0;
        end

        if (bus.en_a && bus.i_dec_valid) dec_bits.push_back(bus.i_dec_bit);
        if (dec_bits.size() == DW) begin
            g = '0;
            for (int i = 0; i < DW; i++) g[DW - 1 - i] = dec_bits[i];
            if (m_dec_valid && !bus.i_dec_frame_ready) m_dec_ovf = 1'b1;
            m_dec_valid = 1'b1;
            m_dec_frame = g;
            m_dec_par   = ^g;
            dec_bits.delete();
        end else if (bus.i_dec_frame_ready) begin
            m_dec_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("enc_frame", bus.o_encoder_frame,   m_enc_frame);
        chk("enc_valid", bus.o_enc_frame_valid, m_enc_valid);
        chk("enc_ovf",   bus.o_enc_overflow,    m_enc_ovf);
        chk("dec_frame", bus.o_decoder_frame,   m_dec_frame);
        chk("dec_valid", bus.o_dec_frame_valid, m_dec_valid);
        chk("dec_ovf",   bus.o_dec_overflow,    m_dec_ovf);
`ifdef FRAME_PARITY_EN
        chk("enc_par",   bus.o_enc_parity,      m_enc_par);
        chk("dec_par",   bus.o_dec_parity,      m_dec_par);
`else
        chk("enc_par",   bus.o_enc_parity,      1'b0);
        chk("dec_par",   bus.o_dec_parity,      1'b0);
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.en_a        = 1'b1;
        bus.i_enc_valid = 1'b0;
        bus.i_enc_sym   = 3'b000;
        bus.i_dec_valid = 1'b0;
        bus.i_dec_bit   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
    endtask

    task automatic feed_enc(input int n, input logic [2:0] s);
        for (int i = 0; i < n; i++) begin
            bus.en_a        = 1'b1;
            bus.i_enc_valid = 1'b1;
            bus.i_enc_sym   = s;
            cycle();
        end
        bus.i_enc_valid = 1'b0;
    endtask

    // mode 0: alternating starting with 1, mode 1: all ones, mode 2: all zeros
    task automatic feed_dec(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            bus.en_a        = 1'b1;
            bus.i_dec_valid = 1'b1;
            bus.i_dec_bit   = (mode == 0) ? ((i % 2) == 0) : (mode == 1);
            cycle();
        end
        bus.i_dec_valid = 1'b0;
    endtask

    typedef struct {
        logic          rate;
        logic [2:0]    sym;
        logic [CW-1:0] frame;
        logic          par;
    } enc_vec_t;

    enc_vec_t vec[5];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepts;

        vec[0] = '{`CODE_RATE_2, 3'b001, {128'h0, {128{2'b10}}}, 1'b0};
        vec[1] = '{`CODE_RATE_3, 3'b001, {32{12'h924}},          1'b0};
        vec[2] = '{`CODE_RATE_2, 3'b111, {128'h0, {256{1'b1}}},  1'b0};
        vec[3] = '{`CODE_RATE_3, 3'b110, {32{12'h6DB}},          1'b0};
        vec[4] = '{`CODE_RATE_2, 3'b010, {128'h0, {128{2'b01}}}, 1'b0};

        rst = 1'b0;
        bus.i_code_rate       = `CODE_RATE_2;
        bus.i_enc_frame_ready = 1'b1;
        bus.i_dec_frame_ready = 1'b1;
        idle_inputs();
        do_reset();
        chk("rst_enc_frame", bus.o_encoder_frame,   '0);
        chk("rst_enc_valid", bus.o_enc_frame_valid, 1'b0);
        chk("rst_dec_valid", bus.o_dec_frame_valid, 1'b0);
        chk("rst_ovf",       {bus.o_enc_overflow, bus.o_dec_overflow}, 2'b00);

        // table-driven encoder frames, ready held high
        for (int k = 0; k < 5; k++) begin
            bus.i_code_rate       = vec[k].rate;
            bus.i_enc_frame_ready = 1'b1;
            do_reset();
            feed_enc(128, vec[k].sym);
            chk($sformatf("tbl%0d_frame", k), bus.o_encoder_frame, vec[k].frame);
            chk($sformatf("tbl%0d_valid", k), bus.o_enc_frame_valid, 1'b1);
`ifdef FRAME_PARITY_EN
            chk($sformatf("tbl%0d_par", k), bus.o_enc_parity, vec[k].par);
`endif
            cycle();
            chk($sformatf("tbl%0d_pulse", k), bus.o_enc_frame_valid, 1'b0);
            chk($sformatf("tbl%0d_hold", k), bus.o_encoder_frame, vec[k].frame);
        end

        // decoder: alternating then all ones
        bus.i_dec_frame_ready = 1'b1;
        do_reset();
        feed_dec(128, 0);
        chk("dec_alt_frame", bus.o_decoder_frame, {64{2'b10}});
        chk("dec_alt_valid", bus.o_dec_frame_valid, 1'b1);
        feed_dec(128, 1);
        chk("dec_ones_frame", bus.o_decoder_frame, {DW{1'b1}});
        chk("dec_ones_valid", bus.o_dec_frame_valid, 1'b1);
`ifdef FRAME_PARITY_EN
        chk("dec_ones_par", bus.o_dec_parity, 1'b0);
`endif

        // decoder overflow with ready held low
        bus.i_dec_frame_ready = 1'b0;
        do_reset();
        feed_dec(128, 1);
        chk("ovf_first_valid", bus.o_dec_frame_valid, 1'b1);
        chk("ovf_first_flag",  bus.o_dec_overflow,    1'b0);
        feed_dec(128, 2);
        chk("ovf_frame", bus.o_decoder_frame,   '0);
        chk("ovf_valid", bus.o_dec_frame_valid, 1'b1);
        chk("ovf_flag",  bus.o_dec_overflow,    1'b1);
        bus.i_dec_frame_ready = 1'b1;
        cycle();
        bus.i_dec_frame_ready = 1'b0;
        chk("ovf_drain_valid", bus.o_dec_frame_valid, 1'b0);
        chk("ovf_sticky",      bus.o_dec_overflow,    1'b1);
        cycle();
        chk("ovf_sticky2",     bus.o_dec_overflow,    1'b1);
        bus.i_dec_frame_ready = 1'b1;

        // rate 1/2 with an enable hole and periodic valid gaps
        bus.i_code_rate       = `CODE_RATE_2;
        bus.i_enc_frame_ready = 1'b1;
        do_reset();
        accepts = 0;
        for (int cyc = 0; cyc < 1000 && accepts < 128; cyc++) begin
            bus.en_a        = !(cyc >= 30 && cyc < 40);
            bus.i_enc_valid = (cyc % 3) != 2;
            bus.i_enc_sym   = 3'b001;
            if (bus.en_a && bus.i_enc_valid) accepts++;
            cycle();
        end
        idle_inputs();
        chk("gap_accepts", accepts, 128);
        chk("gap_frame", bus.o_encoder_frame, {128'h0, {128{2'b10}}});
        chk("gap_valid", bus.o_enc_frame_valid, 1'b1);

        // reset mid-frame, then switch to rate 1/3
        bus.i_code_rate = `CODE_RATE_2;
        do_reset();
        feed_enc(50, 3'b011);
        bus.i_code_rate = `CODE_RATE_3;
        bus.i_enc_valid = 1'b1;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        bus.i_enc_valid = 1'b0;
        chk("midrst_valid", bus.o_enc_frame_valid, 1'b0);
        feed_enc(127, 3'b001);
        chk("midrst_not_yet", bus.o_enc_frame_valid, 1'b0);
        feed_enc(1, 3'b001);
        chk("midrst_frame", bus.o_encoder_frame, {32{12'h924}});
        chk("midrst_valid2", bus.o_enc_frame_valid, 1'b1);

        // randomized traffic on both sides against the reference model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rst                   = !(i == 1700);
            bus.en_a              = $urandom_range(0, 9) != 0;
            bus.i_code_rate       = 1'($urandom_range(0, 1));
            bus.i_enc_valid       = $urandom_range(0, 3) != 0;
            bus.i_enc_sym         = 3'($urandom_range(0, 7));
            bus.i_dec_valid       = $urandom_range(0, 3) != 0;
            bus.i_dec_bit         = 1'($urandom_range(0, 1));
            bus.i_enc_frame_ready = 1'($urandom_range(0, 1));
            bus.i_dec_frame_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        rst = 1'b1;
        idle_inputs();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_assemble.md
Name: frame_assemble

Overview:
- Inverse of the frame slicer: gathers serial symbols and bits and packs them back into parallel frames.
- Encoder side: packs convolutional-encoder symbols (2 bits/symbol at rate 1/2, 3 bits/symbol at rate 1/3) into a 384-bit encoded frame.
- Decoder side: packs Viterbi-decoder output bits into a 128-bit data frame.
- Sits between the encoder/decoder cores and the frame-level host interface. Each side has its own valid/ready output handshake.

Parameters:
- DATA_FRAME_W, 128, decoded data frame width; decoder pointer width is clog2(DATA_FRAME_W).
- CODE_FRAME_W, 384, encoded frame width; 3*DATA_FRAME_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- en_a  in  1  global enable; when 0, no input is accepted and counters hold
- i_code_rate  in  1  `CODE_RATE_2 / `CODE_RATE_3 (param_def.sv)
- i_enc_sym  in  3  encoder symbol; bit0 first, bit2 used at rate 1/3 only
- i_enc_valid  in  1  symbol valid
- i_dec_bit  in  1  decoded bit
- i_dec_valid  in  1  decoded bit valid
- i_enc_frame_ready  in  1  consumer accepts o_encoder_frame
- i_dec_frame_ready  in  1  consumer accepts o_decoder_frame
- o_encoder_frame  out  CODE_FRAME_W  assembled encoded frame
- o_enc_frame_valid  out  1  encoded frame available
- o_decoder_frame  out  DATA_FRAME_W  assembled data frame
- o_dec_frame_valid  out  1  data frame available
- o_enc_overflow  out  1  sticky: encoded frame overwritten before accept
- o_dec_overflow  out  1  sticky: data frame overwritten before accept
- o_enc_parity  out  1  even parity of o_encoder_frame (optional feature)
- o_dec_parity  out  1  even parity of o_decoder_frame (optional feature)

Behaviour:
- Reset (rst==0 at posedge):
  - All outputs 0; shadow registers 0.
  - dec_ptr=127.
  - rate_q = i_code_rate; enc_ptr = 255 if `CODE_RATE_2, 383 if `CODE_RATE_3.
  - Partial frames are discarded. Reset mid-frame behaves identically.
- Encoder accept: en_a & i_enc_valid at posedge.
  - Rate 1/2: shadow[enc_ptr]=sym[0], shadow[enc_ptr-1]=sym[1]; enc_ptr -= 2.
  - Rate 1/3: shadow[enc_ptr]=sym[0], shadow[enc_ptr-1]=sym[1], shadow[enc_ptr-2]=sym[2]; enc_ptr -= 3.
  - i_enc_sym[2] is ignored at rate 1/2.
- Encoder completion: the 128th accept (enc_ptr==1 at rate 1/2, ==2 at rate 1/3).
  - On that same edge, the merged shadow (including the final symbol) loads o_encoder_frame and o_enc_frame_valid=1. Latency: visible 1 cycle after the last accept.
  - On that same edge: shadow cleared; rate_q re-sampled from i_code_rate; enc_ptr reloaded from the new rate.
  - At rate 1/2, bits [383:256] of the frame are 0.
- i_code_rate changes mid-frame have no effect until the next frame boundary.
- Decoder accept: en_a & i_dec_valid.
  - shadow[dec_ptr]=i_dec_bit; dec_ptr -= 1.
  - At dec_ptr==0: load o_decoder_frame, o_dec_frame_valid=1, clear shadow, dec_ptr=127 (wrap).
- Handshake (per side, independent):
  - valid stays high until an edge where ready=1; transfer occurs on that edge.
  - The frame register holds its value after transfer.
  - Completion on the same edge as ready=1: new frame loads, valid stays 1, no overflow.
  - Completion while valid=1 and ready=0: new frame overwrites, valid stays 1, overflow=1 (sticky until reset).
- en_a=0: no accepts, pointers and shadows hold. The handshake still operates (ready clears valid).
- Encoder and decoder sides may accept on the same cycle; they are fully independent.

Optional Feature:
- Macro: FRAME_PARITY_EN.
- Defined:
  - o_enc_parity = XOR of the frame being loaded, registered alongside o_encoder_frame.
  - o_dec_parity is computed the same way from o_decoder_frame.
  - Both update only on frame load.
- Undefined: both parity outputs are tied to 0 and no parity logic is built.

Test Plan:
- Rate 1/2, 128 symbols of 3'b001, ready=1 → 1 cycle after the last accept, valid=1 for 1 cycle. o_encoder_frame[255:0]=256'hAAAA…AA, [383:256]=0. Parity=0 with FRAME_PARITY_EN.
- Rate 1/3, 128 symbols of 3'b001 → o_encoder_frame = 384'h924924…924, valid=1.
- Decoder side: 128 bits alternating starting with 1 → o_decoder_frame=128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA, o_dec_frame_valid=1. Then 128 bits of 1 → 128'hFFFF…FF, parity=0.
- Decoder side, ready=0 throughout: first frame all ones, second frame all zeros → valid stays 1, o_dec_overflow=1, frame=0. Ready=1 for 1 cycle → valid=0, overflow remains 1.
- Rate 1/2 with en_a=0 for 10 cycles and valid gaps every 3rd cycle mid-frame → result identical to the first scenario.
- Reset pulse after 50 rate-1/2 symbols, then i_code_rate switched to rate 1/3 and 128 symbols of 3'b001 → no stale bits; frame = 384'h924…924.
